// File: rtl/mix_seq_ctrl_if.sv
// Handshake/status bundle between a mix-layer sequencer and its ROM users.
// Layer codes and field widths are shared with the sequencer.
`ifndef MIX_SEQ_CTRL_DEFS
`define MIX_SEQ_CTRL_DEFS
`define STATE_LEN 2
`define N_LEN 5
`define MIX1 2'd0
`define MIX2 2'd1
`define MIX3 2'd2
`endif

interface mix_seq_ctrl_if;
  logic                  start;
  logic                  abort;
  logic                  run;
  logic [`STATE_LEN-1:0] state;
  logic                  addr_en;
  logic [`N_LEN-1:0]     addr_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort,
    input  run, state, addr_en, addr_idx, busy, done
  );

  modport slave (
    input  start, abort,
    output run, state, addr_en, addr_idx, busy, done
  );
endinterface

// File: rtl/mix_seq_ctrl.sv
// Sequences MIX1->MIX2->MIX3 run windows with address-advance strobes.
// Every output is a flop loaded from the next-state decode.
module mix_seq_ctrl #(
  parameter int LAYER_CYC  = 102,
  parameter int ADDR_START = 8,
  parameter int ADDR_STEP  = 4,
  parameter int N_ADDR     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  mix_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    RUN,
    DONE
  } fsm_e;

  localparam logic [7:0] CNT_LAST = 8'(LAYER_CYC - 1);

  if ((ADDR_START + ADDR_STEP * (N_ADDR - 1) >= LAYER_CYC) ||
      (LAYER_CYC > 256) || (ADDR_STEP < 1) ||
      (N_ADDR >= (1 << `N_LEN))) begin : g_bad_param
    $error("mix_seq_ctrl: illegal parameter set");
  end

  fsm_e                  fsm_q, fsm_d;
  logic [1:0]            layer_q, layer_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [`N_LEN-1:0]     idx_q, idx_d;
  logic                  run_q, run_d;
  logic                  aen_q, aen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [`STATE_LEN-1:0] code_q, code_d;

  function automatic logic hit(logic [7:0] c);
    int off;
    off = int'(c) - ADDR_START;
    return (off >= 0) && (off % ADDR_STEP == 0) &&
           (off / ADDR_STEP < N_ADDR);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      layer_q <= 2'd0;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      aen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= `MIX1;
    end else begin
      fsm_q   <= fsm_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      aen_q   <= aen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (bus.abort) begin
      fsm_d   = IDLE;
      layer_d = 2'd0;
      cnt_d   = 8'd0;
      idx_d   = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          cnt_d = 8'd0;
          idx_d = '0;
          if (bus.start) begin
            fsm_d   = GAP;
            layer_d = 2'd0;
          end
        end
        GAP: begin
          fsm_d = RUN;
          cnt_d = 8'd0;
          idx_d = '0;
        end
        RUN: begin
          // idx counts strobes already issued, so it trails addr_en
          if (aen_q && (int'(idx_q) < N_ADDR))
            idx_d = idx_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = 8'd0;
            idx_d = '0;
            if (layer_q == 2'd2) begin
              fsm_d   = DONE;
              layer_d = 2'd0;
            end else begin
              fsm_d   = GAP;
              layer_d = layer_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DONE: begin
          fsm_d = IDLE;
          cnt_d = 8'd0;
          idx_d = '0;
        end
        default: fsm_d = IDLE;
      endcase
    end

    run_d  = (fsm_d == RUN);
    busy_d = (fsm_d != IDLE);
    done_d = (fsm_d == DONE);
    aen_d  = (fsm_d == RUN) && hit(cnt_d);
    code_d = `MIX1;
    if ((fsm_d == GAP) || (fsm_d == RUN)) begin
      unique case (1'b1)
        (layer_d == 2'd1): code_d = `MIX2;
        (layer_d == 2'd2): code_d = `MIX3;
        default:           code_d = `MIX1;
      endcase
    end
  end

  assign bus.run      = run_q;
  assign bus.state    = code_q;
  assign bus.addr_en  = aen_q;
  assign bus.addr_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Directed bench for mix_seq_ctrl with a per-cycle expected-output queue.
// Expectations come from the pass timeline: GAP/RUN/GAP/... then DONE.
module tb_mix_seq_ctrl;

  typedef struct packed {
    logic       run;
    logic [1:0] st;
    logic       aen;
    logic [4:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mix_seq_ctrl_if bus();

  mix_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   pc = 0;
  obs_t q[$];

  // c = cycle number within a pass, 0 = idle
  function automatic obs_t exp_at(int c);
    obs_t e;
    int   l, p, cnt, n;
    e = '0;
    if (c >= 1 && c <= 309) begin
      l      = (c - 1) / 103;
      p      = (c - 1) % 103;
      e.busy = 1'b1;
      e.st   = 2'(l);
      if (p >= 1) begin
        cnt   = p - 1;
        e.run = 1'b1;
        e.aen = (cnt >= 8) && (cnt <= 100) && ((cnt - 8) % 4 == 0);
        n     = (cnt <= 8) ? 0 : ((cnt - 9) / 4 + 1);
        if (n > 24) n = 24;
        e.idx = 5'(n);
      end
    end else if (c == 310) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.run  = bus.run;
    o.st   = bus.state;
    o.aen  = bus.addr_en;
    o.idx  = bus.addr_idx;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  task automatic check(string tag, obs_t e);
    obs_t o;
    o = observe();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // called just after a falling edge; drives one cycle of stimulus
  task automatic step(logic s, logic a);
    obs_t e;
    bus.start = s;
    bus.abort = a;
    if (a) pc = 0;
    else if (pc == 0) pc = s ? 1 : 0;
    else if (pc == 310) pc = 0;
    else pc++;
    q.push_back(exp_at(pc));
    @(negedge clk);
    e = q.pop_front();
    check($sformatf("pc%0d", pc), e);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", '0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // single full pass
    step(1'b1, 1'b0);
    repeat (315) step(1'b0, 1'b0);

    // start held high: re-arms only after returning to idle
    repeat (400) step(1'b1, 1'b0);
    repeat (320) step(1'b0, 1'b0);

    // abort during MIX2 run
    step(1'b1, 1'b0);
    repeat (149) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);

    // start with abort in idle
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    // asynchronous reset mid-run
    step(1'b1, 1'b0);
    repeat (58) step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async", '0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", '0);
    end
    rst_n = 1'b1;
    pc = 0;
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_seq_ctrl.md
MIX_SEQ_CTRL -- requirements
Module: mix_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LAYER_CYC, default 102, giving run-high cycles per mix layer (layer counter counts 0..LAYER_CYC-1).
REQ-002 The block SHALL have parameter ADDR_START, default 8, giving the counter value of the first address-advance strobe.
REQ-003 The block SHALL have parameter ADDR_STEP, default 4, giving counter spacing between address-advance strobes.
REQ-004 The block SHALL have parameter N_ADDR, default 24, giving address-advance strobes per layer.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a full MIX1->MIX2->MIX3 pass; sampled only in IDLE.
REQ-008 abort  input  1  synchronous cancel; return to IDLE on the next edge.
REQ-009 run  output  1  run enable to bias/weight ROM sequencers; low in IDLE/GAP/DONE.
REQ-010 state  output  `STATE_LEN  layer code (`MIX1/`MIX2/`MIX3) for ROM bias-base selection.
REQ-011 addr_en  output  1  one-cycle strobe: ROM address advances this cycle.
REQ-012 addr_idx  output  `N_LEN  index within layer (strobes already issued), for debug/checking.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when MIX3 completes.

Function
REQ-015 FSM states SHALL be IDLE, GAP, RUN, DONE, plus a 2-bit layer register (0=MIX1,1=MIX2,2=MIX3).
REQ-016 IDLE with start=1 SHALL go to GAP with layer=0; start outside IDLE SHALL be ignored.
REQ-017 GAP SHALL last exactly 1 cycle with run=0, cnt=0, addr_idx=0, then go to RUN.
REQ-018 In GAP and RUN, state SHALL equal the code of the current layer; in IDLE and DONE, state SHALL be `MIX1.
REQ-019 RUN SHALL hold run=1 for exactly LAYER_CYC cycles, 8-bit cnt incrementing 0..LAYER_CYC-1.
REQ-020 At cnt=LAYER_CYC-1, layer 0/1 SHALL go to GAP with layer+1; layer 2 SHALL go to DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, then go to IDLE; done SHALL be 0 elsewhere.
REQ-022 addr_en SHALL be 1 in RUN iff cnt=ADDR_START+ADDR_STEP*k for integer k with 0<=k<N_ADDR, and 0 otherwise.
REQ-023 addr_idx SHALL increment the edge after each addr_en, saturating at N_ADDR, and clear to 0 in GAP.
REQ-024 Cycles numbered from 1 after the start-sampling edge (defaults): GAP 1, RUN-MIX1 2..103, GAP 104, RUN-MIX2 105..206, GAP 207, RUN-MIX3 208..309, DONE 310.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge (run=0, busy=0, cnt=0, addr_idx=0, no done pulse); abort has priority over start.
REQ-026 start=1 together with abort=1 in IDLE SHALL leave the block in IDLE.
REQ-027 Any parameter set with ADDR_START+ADDR_STEP*(N_ADDR-1) >= LAYER_CYC or LAYER_CYC > 256 SHALL be illegal, flagged by an elaboration-time check.
REQ-028 All outputs SHALL be registered (no combinational path from start/abort to outputs).

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, layer=0, cnt=0, addr_idx=0, run=0, addr_en=0, busy=0, done=0, state=`MIX1.
REQ-030 Reset asserted mid-RUN SHALL drop run the same cycle; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-031 Single start pulse in IDLE -> run high cycles 2..103, 105..206, 208..309; state MIX1/MIX2/MIX3; done=1 only in cycle 310; busy cycles 1..310.
REQ-032 Within one RUN phase -> exactly 24 addr_en strobes at cnt 8,12,...,100; addr_idx reaches 24 and holds.
REQ-033 start held high continuously -> new pass begins only after return to IDLE (cycle 311 samples, GAP at 312).
REQ-034 abort at cycle 150 (MIX2 RUN) -> run=0, busy=0, state=`MIX1 from cycle 151; no done pulse.
REQ-035 rst_n low at cycle 60 for 3 cycles -> outputs at reset values immediately; no activity until next start.
REQ-036 start and abort high together in IDLE -> block stays IDLE, busy remains 0.
